// File: rtl/fcnn_pkg.sv
// Shared state encoding, default layer geometry and address widths for the FCNN sequencer.
// Used by fcnn_sequencer (optional hold feature: FCNN_SEQ_HOLD_EN).
package fcnn_pkg;

    localparam int unsigned DefNsIn     = 784;
    localparam int unsigned DefNsHidden = 30;
    localparam int unsigned DefNsOut    = 10;

    // Layer-1 weights sit directly after the layer-0 weight block.
    localparam int unsigned DefL1WeightBase = DefNsHidden * DefNsIn;

    localparam int unsigned WAddrW  = 15;
    localparam int unsigned XAddrW  = 10;
    localparam int unsigned NeuronW = 5;
    localparam int unsigned BiasW   = 6;

    typedef enum logic [2:0] {
        StIdle,
        StL0Mac,
        StL0Drain,
        StL0Wb,
        StL1Mac,
        StL1Drain,
        StL1Wb,
        StDone
    } state_e;

    function automatic int unsigned l1_weight_base(int unsigned ns_hidden, int unsigned ns_in);
        return ns_hidden * ns_in;
    endfunction

endpackage

// File: rtl/fcnn_idx_counter.sv
// Saturating index counter: synchronous clear-to-zero load, increment that stops at last_i,
// and a terminal-count flag.
module fcnn_idx_counter #(
    parameter int unsigned Width = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             inc_i,
    input  logic [Width-1:0] last_i,
    output logic [Width-1:0] cnt_o,
    output logic             tc_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    assign tc_o  = (cnt_q == last_i);
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (inc_i && !tc_o) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fcnn_sequencer.sv
// Control sequencer for a two-layer fully connected network: walks weight/activation addresses,
// strobes MAC and write-back. Define FCNN_SEQ_HOLD_EN to add the hold backpressure port.
module fcnn_sequencer
    import fcnn_pkg::*;
#(
    parameter int unsigned dataWidth = 16,
    parameter int unsigned NsIn      = DefNsIn,
    parameter int unsigned NsHidden  = DefNsHidden,
    parameter int unsigned NsOut     = DefNsOut
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
`ifdef FCNN_SEQ_HOLD_EN
    input  logic                hold,
`endif
    output logic                busy,
    output logic                done,
    output logic                wRdEn,
    output logic [WAddrW-1:0]   wAddr,
    output logic [XAddrW-1:0]   xAddr,
    output logic                xSel,
    output logic                macEn,
    output logic                macClr,
    output logic                actWr,
    output logic [NeuronW-1:0]  actAddr,
    output logic                actLayer,
    output logic [BiasW-1:0]    biasAddr
);

    localparam int unsigned L1Base = l1_weight_base(NsHidden, NsIn);

    state_e state_q, state_d;
    logic   layer_q, layer_d;
    logic   mac_en_q, mac_en_d;
    logic   frz;

    logic               i_load, i_inc, i_tc;
    logic               j_load, j_inc, j_tc;
    logic [XAddrW-1:0]  i_cnt, i_last;
    logic [NeuronW-1:0] j_cnt, j_last;

`ifdef FCNN_SEQ_HOLD_EN
    assign frz = hold;
`else
    assign frz = 1'b0;
`endif

    assign i_last = layer_q ? XAddrW'(NsHidden - 1) : XAddrW'(NsIn - 1);
    assign j_last = layer_q ? NeuronW'(NsOut - 1) : NeuronW'(NsHidden - 1);

    fcnn_idx_counter #(
        .Width (XAddrW)
    ) u_in_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .load_i (i_load),
        .inc_i  (i_inc),
        .last_i (i_last),
        .cnt_o  (i_cnt),
        .tc_o   (i_tc)
    );

    fcnn_idx_counter #(
        .Width (NeuronW)
    ) u_neuron_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .load_i (j_load),
        .inc_i  (j_inc),
        .last_i (j_last),
        .cnt_o  (j_cnt),
        .tc_o   (j_tc)
    );

    always_comb begin
        state_d  = state_q;
        layer_d  = layer_q;
        i_load   = 1'b0;
        i_inc    = 1'b0;
        j_load   = 1'b0;
        j_inc    = 1'b0;
        wRdEn    = 1'b0;
        macClr   = 1'b0;
        actWr    = 1'b0;
        actLayer = 1'b0;
        done     = 1'b0;
        xSel     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StL0Mac;
                    layer_d = 1'b0;
                    i_load  = 1'b1;
                    j_load  = 1'b1;
                end
            end
            StL0Mac, StL1Mac: begin
                wRdEn = 1'b1;
                xSel  = (state_q == StL1Mac);
                if (i_tc) begin
                    state_d = (state_q == StL0Mac) ? StL0Drain : StL1Drain;
                end else begin
                    i_inc = 1'b1;
                end
            end
            StL0Drain: state_d = StL0Wb;
            StL1Drain: state_d = StL1Wb;
            StL0Wb: begin
                actWr  = 1'b1;
                macClr = 1'b1;
                i_load = 1'b1;
                if (j_tc) begin
                    state_d = StL1Mac;
                    layer_d = 1'b1;
                    j_load  = 1'b1;
                end else begin
                    state_d = StL0Mac;
                    j_inc   = 1'b1;
                end
            end
            StL1Wb: begin
                actWr    = 1'b1;
                macClr   = 1'b1;
                actLayer = 1'b1;
                // Leave the input index at its terminal value so addresses hold through DONE.
                if (j_tc) begin
                    state_d = StDone;
                end else begin
                    state_d = StL1Mac;
                    i_load  = 1'b1;
                    j_inc   = 1'b1;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (frz) begin
            state_d = state_q;
            layer_d = layer_q;
            i_load  = 1'b0;
            i_inc   = 1'b0;
            j_load  = 1'b0;
            j_inc   = 1'b0;
            wRdEn   = 1'b0;
            macClr  = 1'b0;
            actWr   = 1'b0;
            done    = 1'b0;
        end

        mac_en_d = wRdEn;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            layer_q  <= 1'b0;
            mac_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            layer_q  <= layer_d;
            mac_en_q <= mac_en_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign macEn   = mac_en_q;
    assign xAddr   = i_cnt;
    assign actAddr = j_cnt;
    assign wAddr   = layer_q
                   ? WAddrW'(L1Base) + WAddrW'(j_cnt) * WAddrW'(NsHidden) + WAddrW'(i_cnt)
                   : WAddrW'(j_cnt) * WAddrW'(NsIn) + WAddrW'(i_cnt);
    assign biasAddr = layer_q ? BiasW'(NsHidden) + BiasW'(j_cnt) : BiasW'(j_cnt);

endmodule

// File: tb/tb_fcnn_sequencer.sv
// Self-checking bench for fcnn_sequencer: cycle-indexed expectation table over a full run,
// plus hand-written reset, restart and (with FCNN_SEQ_HOLD_EN) hold sequences.
module tb_fcnn_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, hold;
    logic        busy, done, wRdEn, xSel, macEn, macClr, actWr, actLayer;
    logic [14:0] wAddr;
    logic [9:0]  xAddr;
    logic [4:0]  actAddr;
    logic [5:0]  biasAddr;

    typedef struct {
        int          cyc;
        string       name;
        logic [43:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fcnn_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef FCNN_SEQ_HOLD_EN
        .hold     (hold),
`endif
        .busy     (busy),
        .done     (done),
        .wRdEn    (wRdEn),
        .wAddr    (wAddr),
        .xAddr    (xAddr),
        .xSel     (xSel),
        .macEn    (macEn),
        .macClr   (macClr),
        .actWr    (actWr),
        .actAddr  (actAddr),
        .actLayer (actLayer),
        .biasAddr (biasAddr)
    );

    // Field order: busy done wRdEn macEn macClr actWr xSel actLayer | wAddr xAddr actAddr biasAddr
    function automatic logic [43:0] mk(bit b, bit d, bit wr, bit me, bit clr, bit aw, bit xs,
                                       bit al, int wa, int xa, int aa, int ba);
        return {b, d, wr, me, clr, aw, xs, al, 15'(wa), 10'(xa), 5'(aa), 6'(ba)};
    endfunction

    function automatic logic [43:0] snap();
        return {busy, done, wRdEn, macEn, macClr, actWr, xSel, actLayer,
                wAddr, xAddr, actAddr, biasAddr};
    endfunction

    task automatic chk(string name, logic [43:0] exp);
        logic [43:0] act;
        act = snap();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got flags=%b w=%0d x=%0d a=%0d b=%0d, want flags=%b w=%0d x=%0d a=%0d b=%0d",
                     name, act[43:36], act[35:21], act[20:11], act[10:6], act[5:0],
                     exp[43:36], exp[35:21], exp[20:11], exp[10:6], exp[5:0]);
        end
    endtask

    task automatic chk_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic add(int c, string n, logic [43:0] e);
        vec_t v;
        v.cyc  = c;
        v.name = n;
        v.exp  = e;
        tbl.push_back(v);
    endtask

    initial begin
        int   tidx     = 0;
        int   done_cnt = 0;
        int   done_cyc = -1;
        int   mac_bad  = 0;
        logic prev_wr  = 1'b0;

        add(1,     "first_beat",      mk(1,0,1,0,0,0,0,0, 0,     0,   0, 0));
        add(2,     "second_beat",     mk(1,0,1,1,0,0,0,0, 1,     1,   0, 0));
        add(784,   "l0n0_last",       mk(1,0,1,1,0,0,0,0, 783,   783, 0, 0));
        add(785,   "l0n0_drain",      mk(1,0,0,1,0,0,0,0, 783,   783, 0, 0));
        add(786,   "l0n0_wb",         mk(1,0,0,0,1,1,0,0, 783,   783, 0, 0));
        add(787,   "l0n1_first",      mk(1,0,1,0,0,0,0,0, 784,   0,   1, 1));
        add(22795, "l0n29_first",     mk(1,0,1,0,0,0,0,0, 22736, 0,   29, 29));
        add(23578, "l0n29_last",      mk(1,0,1,1,0,0,0,0, 23519, 783, 29, 29));
        add(23580, "l0n29_wb",        mk(1,0,0,0,1,1,0,0, 23519, 783, 29, 29));
        add(23581, "l1n0_first",      mk(1,0,1,0,0,0,1,0, 23520, 0,   0, 30));
        add(23612, "l1n0_wb",         mk(1,0,0,0,1,1,0,1, 23549, 29,  0, 30));
        add(23869, "l1n9_first",      mk(1,0,1,0,0,0,1,0, 23790, 0,   9, 39));
        add(23898, "l1n9_last",       mk(1,0,1,1,0,0,1,0, 23819, 29,  9, 39));
        add(23899, "l1n9_drain",      mk(1,0,0,1,0,0,0,0, 23819, 29,  9, 39));
        add(23900, "l1n9_wb",         mk(1,0,0,0,1,1,0,1, 23819, 29,  9, 39));
        add(23901, "done_pulse",      mk(1,1,0,0,0,0,0,0, 23819, 29,  9, 39));
        add(23902, "idle_after_done", mk(0,0,0,0,0,0,0,0, 23819, 29,  9, 39));
        add(23903, "held_start_rerun", mk(1,0,1,0,0,0,0,0, 0,    0,   0, 0));

        rst   = 1'b0;
        start = 1'b0;
        hold  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", '0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_no_start", '0);

        // start stays high for the whole first run: only one done, then an immediate rerun.
        start = 1'b1;
        for (int c = 1; c <= 23903; c++) begin
            @(negedge clk);
            if (macEn !== prev_wr) mac_bad++;
            prev_wr = wRdEn;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = c;
            end
            if (tidx < tbl.size() && tbl[tidx].cyc == c) begin
                chk(tbl[tidx].name, tbl[tidx].exp);
                tidx++;
            end
        end
        start = 1'b0;
        chk_int("macen_tracks_rden", mac_bad, 0);
        chk_int("done_count", done_cnt, 1);
        chk_int("done_cycle", done_cyc, 23901);

        // Second run is at its cycle 1; advance to cycle 5000 (neuron 6, i=283).
        repeat (4999) @(negedge clk);
        chk("run2_c5000", mk(1,0,1,1,0,0,0,0, 4987, 283, 6, 6));
        rst   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        chk("reset_mid_run", '0);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", '0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_first", mk(1,0,1,0,0,0,0,0, 0, 0, 0, 0));
        @(negedge clk);
        chk("restart_second", mk(1,0,1,1,0,0,0,0, 1, 1, 0, 0));

`ifdef FCNN_SEQ_HOLD_EN
        begin
            int hold_bad = 0;
            repeat (99) @(negedge clk);
            hold = 1'b1;
            #1;
            chk("hold_first", mk(1,0,0,1,0,0,0,0, 100, 100, 0, 0));
            repeat (6) begin
                @(negedge clk);
                #1;
                if (snap() !== mk(1,0,0,0,0,0,0,0, 100, 100, 0, 0)) hold_bad++;
            end
            chk_int("hold_quiet", hold_bad, 0);
            @(negedge clk);
            hold = 1'b0;
            #1;
            chk("hold_resume", mk(1,0,1,0,0,0,0,0, 100, 100, 0, 0));
            done_cnt = 0;
            done_cyc = -1;
            for (int c = 109; c <= 23910; c++) begin
                @(negedge clk);
                if (done === 1'b1) begin
                    done_cnt++;
                    done_cyc = c;
                end
            end
            chk_int("hold_done_count", done_cnt, 1);
            chk_int("hold_done_cycle", done_cyc, 23908);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
